// File: rtl/canvas_pkg.sv
// Shared canvas constants, FSM state encoding and read-tag payload for the
// canvas_reader block.
package canvas_pkg;

    localparam int unsigned CANVAS_WIDTH  = 320;
    localparam int unsigned CANVAS_HEIGHT = 240;
    localparam int unsigned ADDR_W        = 17;
    localparam int unsigned COLOR_W       = 3;
    localparam int unsigned X_W           = 9;
    localparam int unsigned Y_W           = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // One outstanding RAM read: the pixel it belongs to and whether it is real.
    typedef struct packed {
        logic           valid;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } tag_t;

endpackage

// File: rtl/canvas_reader_tag_pipe.sv
// Fixed-depth shift register carrying pixel tags alongside the RAM read
// latency, so each tag leaves the pipe on the edge its read data is valid.
// Ports:
//   clock, reset : clock and async active-high reset (clears all stages)
//   issue        : tag entering stage 0 every edge
//   retire       : tag leaving the last stage
//   occupied_c   : any stage holds a valid tag (combinational OR of stages)
module canvas_reader_tag_pipe
    import canvas_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)(
    input  logic clock,
    input  logic reset,
    input  tag_t issue,
    output tag_t retire,
    output logic occupied_c
);

    tag_t stage [DEPTH];

    // Shift one stage per edge; stage 0 always takes the new tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= issue;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign retire = stage[DEPTH-1];

    always_comb begin
        occupied_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied_c = occupied_c | stage[i].valid;
        end
    end

endmodule

// File: rtl/canvas_reader.sv
// Scans the canvas RAM once per start request in raster order and streams
// each pixel to the VGA adapter with its coordinates.
// Ports:
//   clock, reset : single clock, async active-high reset
//   start        : frame request, honoured only in IDLE
//   enable       : issue gate for new reads during the scan
//   q            : canvas RAM read data (READ_LATENCY edges after addr)
//   addr         : canvas RAM read address (y*WIDTH + x)
//   VGA_X/VGA_Y  : pixel coordinates, valid with plot
//   VGA_COLOR    : pixel colour, valid with plot
//   plot         : one pixel presented this cycle
//   busy         : frame in progress (not during the done cycle)
//   done         : one-cycle pulse after the final pixel
module canvas_reader
    import canvas_pkg::*;
#(
    parameter int unsigned WIDTH        = CANVAS_WIDTH,
    parameter int unsigned HEIGHT       = CANVAS_HEIGHT,
    parameter int unsigned READ_LATENCY = 2
)(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               enable,
    input  logic [COLOR_W-1:0] q,
    output logic [ADDR_W-1:0]  addr,
    output logic [X_W-1:0]     VGA_X,
    output logic [Y_W-1:0]     VGA_Y,
    output logic [COLOR_W-1:0] VGA_COLOR,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_next;
    logic [X_W-1:0]      x_cnt;
    logic [X_W-1:0]      x_next;
    logic [Y_W-1:0]      y_cnt;
    logic [Y_W-1:0]      y_next;
    logic                busy_next;
    logic                done_next;
    tag_t                issue_tag;
    tag_t                retire_tag;
    logic                pipe_occupied_c;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, issue counters and tag to push.
    always_comb begin
        state_next      = state;
        addr_next       = addr;
        x_next          = x_cnt;
        y_next          = y_cnt;
        issue_tag.valid = 1'b0;
        issue_tag.x     = x_cnt;
        issue_tag.y     = y_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    addr_next  = '0;
                    x_next     = '0;
                    y_next     = '0;
                end
            end
            SCAN: begin
                if (enable) begin
                    issue_tag.valid = 1'b1;
                    // The last pixel parks addr so the RAM keeps a legal address.
                    if (x_cnt == X_LAST && y_cnt == Y_LAST) begin
                        state_next = DRAIN;
                    end else begin
                        addr_next = addr + ADDR_W'(1);
                        if (x_cnt == X_LAST) begin
                            x_next = '0;
                            y_next = y_cnt + Y_W'(1);
                        end else begin
                            x_next = x_cnt + X_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (!pipe_occupied_c) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == SCAN) || (state_next == DRAIN);
        done_next = (state_next == FINISH);
    end

    // Issue counters and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr  <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            addr  <= addr_next;
            x_cnt <= x_next;
            y_cnt <= y_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    canvas_reader_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clock      (clock),
        .reset      (reset),
        .issue      (issue_tag),
        .retire     (retire_tag),
        .occupied_c (pipe_occupied_c)
    );

    // A retiring tag pairs with the RAM data present on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            plot      <= 1'b0;
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= '0;
        end else begin
            plot <= retire_tag.valid;
            if (retire_tag.valid) begin
                VGA_X     <= retire_tag.x;
                VGA_Y     <= retire_tag.y;
                VGA_COLOR <= q;
            end
        end
    end

endmodule

// File: tb/tb_canvas_reader.sv
// Self-checking bench for canvas_reader on a reduced canvas: expected pixel
// stream is queued at start and consumed by an independent plot/done monitor.
module tb_canvas_reader;

    localparam int unsigned W    = 20;
    localparam int unsigned H    = 10;
    localparam int unsigned RL   = 2;
    localparam int          NPIX = W * H;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        enable;
    logic [2:0]  q;
    logic [16:0] addr;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_color;
    logic        plot;
    logic        busy;
    logic        done;

    canvas_reader #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .READ_LATENCY (RL)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .enable    (enable),
        .q         (q),
        .addr      (addr),
        .VGA_X     (vga_x),
        .VGA_Y     (vga_y),
        .VGA_COLOR (vga_color),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Canvas RAM model: data = addr[2:0], valid RL edges after addr changes.
    logic [16:0] ram_pipe [RL];
    always @(posedge clock) begin
        ram_pipe[0] <= addr;
        for (int i = 1; i < RL; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign q = ram_pipe[RL-1][2:0];

    typedef struct {
        int x;
        int y;
        int color;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   frame_plots = 0;
    int   last_plot_cyc = -10;
    bit   frame_active = 1'b0;
    int   done_count = 0;

    always @(posedge clock) cyc++;

    // Monitor: every plot must match the head of the expected stream; done
    // must follow the final plot by exactly one cycle with busy low.
    always @(negedge clock) begin
        if (!reset) begin
            if (plot) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_plot actual x=%0d y=%0d c=%0d required no plot",
                             vga_x, vga_y, vga_color);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (int'(vga_x) != mon_e.x || int'(vga_y) != mon_e.y ||
                        int'(vga_color) != mon_e.color) begin
                        failures++;
                        $display("FAIL pixel actual (%0d,%0d) c=%0d required (%0d,%0d) c=%0d",
                                 vga_x, vga_y, vga_color, mon_e.x, mon_e.y, mon_e.color);
                    end
                end
                frame_plots++;
                last_plot_cyc = cyc;
            end
            if (done) begin
                checks++;
                if (!frame_active || exp_q.size() != 0 || cyc != last_plot_cyc + 1 || busy) begin
                    failures++;
                    $display("FAIL done_pulse actual active=%0d left=%0d gap=%0d busy=%0d required 1/0/1/0",
                             frame_active, exp_q.size(), cyc - last_plot_cyc, busy);
                end
                frame_active = 1'b0;
                done_count++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  int'(addr),      0);
        check({tag, "_vga_x"}, int'(vga_x),     0);
        check({tag, "_vga_y"}, int'(vga_y),     0);
        check({tag, "_color"}, int'(vga_color), 0);
        check({tag, "_plot"},  int'(plot),      0);
        check({tag, "_busy"},  int'(busy),      0);
        check({tag, "_done"},  int'(done),      0);
    endtask

    function automatic logic en_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 2) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One frame request. mode: 0 enable high, 1 toggle, 2 random.
    // restart_at/reset_at: plot count at which to pulse start / assert reset.
    task automatic run_frame(input int mode, input int restart_at, input int reset_at,
                             input bit start_in_finish);
        int  k;
        int  dc;
        bit  first_seen;
        bit  restarted;
        bit  finished;

        frame_plots = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back('{x, y, (y * W + x) % 8});
        frame_active = 1'b1;
        dc = done_count;

        @(negedge clock); #1;
        start  = 1'b1;
        enable = en_for(mode, 0);
        @(negedge clock); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);

        k = 0;
        first_seen = 1'b0;
        restarted  = 1'b0;
        finished   = 1'b0;
        while (!finished && k < 4 * NPIX + 50) begin
            enable = en_for(mode, k + 1);
            start  = 1'b0;
            @(negedge clock); #1;
            k++;
            if (plot && !first_seen) begin
                first_seen = 1'b1;
                if (mode == 0) check("first_plot_latency", k, RL + 1);
            end
            if (restart_at > 0 && !restarted && frame_plots >= restart_at) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (reset_at > 0 && frame_plots >= reset_at) begin
                #2 reset = 1'b1;
                #1 check_all_zero("async_reset");
                exp_q.delete();
                frame_active = 1'b0;
                repeat (2) @(negedge clock);
                #1 reset = 1'b0;
                repeat (10) @(negedge clock);
                #1;
                check("after_abort_busy", int'(busy), 0);
                check("after_abort_done", done_count - dc, 0);
                return;
            end
            if (done_count != dc) finished = 1'b1;
        end

        if (!finished) begin
            failures++;
            $display("FAIL frame_timeout actual plots=%0d required %0d", frame_plots, NPIX);
            exp_q.delete();
            frame_active = 1'b0;
            return;
        end

        if (start_in_finish) begin
            // done is showing, so the DUT is in FINISH for this edge.
            start = 1'b1;
            @(negedge clock); #1;
            start = 1'b0;
        end
        check("plot_count", frame_plots, NPIX);
        check("queue_empty", exp_q.size(), 0);
        check("addr_parked", int'(addr), NPIX - 1);
        if (mode == 1) check("toggle_length_doubled", int'(k >= 2 * NPIX - 2), 1);
        repeat (10) @(negedge clock);
        #1;
        check("single_done", done_count - dc, 1);
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        enable = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clock); #1;
        reset = 1'b0;
        @(negedge clock); #1;
        check_all_zero("idle");

        run_frame(0, 0, 0, 1'b1);
        run_frame(1, 0, 0, 1'b0);
        run_frame(2, 50, 0, 1'b0);
        run_frame(0, 0, 100, 1'b0);
        run_frame(0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
